// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame scheduler.
// Holds the FSM state enum, packet constants and flag-byte layout.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PUBLISH,
        READY,
        LOCKED
    } state_t;

    localparam logic [7:0] HEADER_BYTE  = 8'hAA;
    localparam int         PACKET_SIZE  = 16;

    localparam int FLAG_QUAT    = 0;
    localparam int FLAG_GYRO    = 1;
    localparam int FLAG_OVR     = 2;
    localparam int FLAG_SEQ_LSB = 3;

    function automatic logic [7:0] pack_flags(
        input logic [4:0] seq,
        input logic       ovr,
        input logic       gyro,
        input logic       quat
    );
        logic [7:0] f;
        f                 = '0;
        f[FLAG_QUAT]      = quat;
        f[FLAG_GYRO]      = gyro;
        f[FLAG_OVR]       = ovr;
        f[7:FLAG_SEQ_LSB] = seq;
        return f;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer, reset value set by RST_VAL.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronized out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Sequences quat/gyro updates into a frozen frame for the SPI slave.
// Ports: clk, rst_n, cs_n, quat_valid/quat_*, gyro_valid/gyro_*,
// frame_* (published frame), frame_flags, drdy, overrun_cnt, stale.
module spi_frame_scheduler
    import spi_pkg::*;
#(
    parameter int COLLECT_WINDOW = 48_000,
    parameter int STALE_CYCLES   = 4_800_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        quat_valid,
    input  logic [15:0] quat_w,
    input  logic [15:0] quat_x,
    input  logic [15:0] quat_y,
    input  logic [15:0] quat_z,
    input  logic        gyro_valid,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    output logic [15:0] frame_quat_w,
    output logic [15:0] frame_quat_x,
    output logic [15:0] frame_quat_y,
    output logic [15:0] frame_quat_z,
    output logic [15:0] frame_gyro_x,
    output logic [15:0] frame_gyro_y,
    output logic [15:0] frame_gyro_z,
    output logic [7:0]  frame_flags,
    output logic        drdy,
    output logic [7:0]  overrun_cnt,
    output logic        stale
);

    localparam int CW = $clog2(COLLECT_WINDOW + 1);
    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam logic [CW-1:0] WIN_LAST  = CW'(COLLECT_WINDOW - 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

    state_t      state;
    logic        cs_s;
    logic        cs_prev;
    logic        cs_fall;
    logic        cs_rise;
    logic [15:0] sh_qw, sh_qx, sh_qy, sh_qz;
    logic [15:0] sh_gx, sh_gy, sh_gz;
    logic        q_new;
    logic        g_new;
    logic        ovr_pend;
    logic [4:0]  seq;
    logic [CW-1:0] win_cnt;
    logic [SW-1:0] stale_cnt;
    logic        qn;
    logic        gn;
    logic        pending;
    logic        win_done;
    logic        pub_cond;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cs_n),
        .q    (cs_s)
    );

    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;

    // Include this cycle's pulses so a completing update publishes
    // on the very next cycle.
    assign qn       = q_new | quat_valid;
    assign gn       = g_new | gyro_valid;
    assign pending  = q_new | g_new;
    assign win_done = (win_cnt == WIN_LAST);
    assign pub_cond = (qn & gn) | (pending & win_done);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cs_prev      <= 1'b1;
            sh_qw        <= '0;
            sh_qx        <= '0;
            sh_qy        <= '0;
            sh_qz        <= '0;
            sh_gx        <= '0;
            sh_gy        <= '0;
            sh_gz        <= '0;
            q_new        <= 1'b0;
            g_new        <= 1'b0;
            ovr_pend     <= 1'b0;
            seq          <= '0;
            win_cnt      <= '0;
            stale_cnt    <= '0;
            frame_quat_w <= '0;
            frame_quat_x <= '0;
            frame_quat_y <= '0;
            frame_quat_z <= '0;
            frame_gyro_x <= '0;
            frame_gyro_y <= '0;
            frame_gyro_z <= '0;
            frame_flags  <= '0;
            drdy         <= 1'b0;
            overrun_cnt  <= '0;
            stale        <= 1'b0;
        end else begin
            cs_prev <= cs_s;

            if (quat_valid) begin
                sh_qw <= quat_w;
                sh_qx <= quat_x;
                sh_qy <= quat_y;
                sh_qz <= quat_z;
                q_new <= 1'b1;
            end
            if (gyro_valid) begin
                sh_gx <= gyro_x;
                sh_gy <= gyro_y;
                sh_gz <= gyro_z;
                g_new <= 1'b1;
            end

            if (quat_valid | gyro_valid) begin
                stale_cnt <= '0;
                stale     <= 1'b0;
            end else begin
                if (stale_cnt != STALE_MAX)
                    stale_cnt <= stale_cnt + 1'b1;
                if (stale_cnt >= STALE_MAX - 1'b1)
                    stale <= 1'b1;
            end

            // Window saturates at its terminal value so a held-off
            // publish fires as soon as CS goes high.
            if ((state == COLLECT || state == READY || state == LOCKED)
                && pending && !win_done)
                win_cnt <= win_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    drdy <= 1'b0;
                    if (qn & gn & cs_s)
                        state <= PUBLISH;
                    else if (qn | gn)
                        state <= COLLECT;
                end
                COLLECT: begin
                    if (pub_cond && cs_s)
                        state <= PUBLISH;
                end
                PUBLISH: begin
                    frame_quat_w <= sh_qw;
                    frame_quat_x <= sh_qx;
                    frame_quat_y <= sh_qy;
                    frame_quat_z <= sh_qz;
                    frame_gyro_x <= sh_gx;
                    frame_gyro_y <= sh_gy;
                    frame_gyro_z <= sh_gz;
                    frame_flags  <= pack_flags(seq + 5'd1, ovr_pend,
                                               g_new, q_new);
                    seq          <= seq + 5'd1;
                    // A pulse landing now belongs to the next frame.
                    q_new        <= quat_valid;
                    g_new        <= gyro_valid;
                    ovr_pend     <= 1'b0;
                    win_cnt      <= '0;
                    drdy         <= ~cs_fall;
                    state        <= cs_fall ? LOCKED : READY;
                end
                READY: begin
                    if (cs_fall) begin
                        drdy  <= 1'b0;
                        state <= LOCKED;
                    end else if (cs_s && pub_cond) begin
                        if (overrun_cnt != 8'hFF)
                            overrun_cnt <= overrun_cnt + 8'd1;
                        ovr_pend <= 1'b1;
                        state    <= PUBLISH;
                    end
                end
                LOCKED: begin
                    if (cs_rise)
                        state <= (qn | gn) ? COLLECT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_frame_scheduler.md
# spi_frame_scheduler

Clock-domain controller that sequences sensor frames into the MCU SPI read path. It collects quaternion and gyro update pulses from the BNO085 controller into a shadow frame and publishes a frozen frame to the SPI slave only while the bus is idle. It raises a data-ready line to the MCU and holds the published frame stable for the whole CS-low transaction. It also tracks dropped frames and sensor staleness. It sits between the BNO085 controller and the SPI slave, entirely in the FPGA `clk` domain.

## Interface
- `COLLECT_WINDOW`, default 48_000: max cycles a partial frame waits for its partner update before publishing anyway.
- `STALE_CYCLES`, default 4_800_000: cycles without any valid pulse before `stale` asserts.
- `clk`  in  1  FPGA system clock; the block's only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cs_n`  in  1  raw MCU chip select, asynchronous; synchronized internally.
- `quat_valid`  in  1  one-cycle update pulse.
- `quat_w/x/y/z`  in  16 each, signed  quaternion sample.
- `gyro_valid`  in  1  one-cycle update pulse.
- `gyro_x/y/z`  in  16 each, signed  gyro sample.
- `frame_quat_w/x/y/z`, `frame_gyro_x/y/z`  out  16 each  published frame fields, to the SPI slave.
- `frame_flags`  out  8  published flags byte: bit0 quat fresh, bit1 gyro fresh, bit2 overrun since last read, bits7:3 seq[4:0].
- `drdy`  out  1  data-ready to MCU GPIO, active high.
- `overrun_cnt`  out  8  saturating count of frames published but never read.
- `stale`  out  1  no sensor update within `STALE_CYCLES`.

## Operation
- `cs_n` passes through a 2-FF synchronizer. Both sync flops reset to 1. `cs_fall` and `cs_rise` are detected on the synchronized output.
- Shadow registers:
  - A `quat_valid` pulse loads the quat shadow and sets `q_new`.
  - A `gyro_valid` pulse loads the gyro shadow and sets `g_new`.
  - Shadow loading occurs in every state, including LOCKED.
- States:
  - **IDLE**: `drdy`=0. Go to COLLECT when `q_new|g_new`.
  - **COLLECT**: the window counter increments each cycle. Publish when `q_new&g_new`, or when the counter reaches `COLLECT_WINDOW-1`.
    - If synchronized CS is high, go to PUBLISH.
    - Otherwise stay and hold the counter at its terminal value.
  - **PUBLISH** (1 cycle):
    - Copy shadow to frame registers.
    - `flags[1:0]={g_new,q_new}`, `flags[2]=ovr_pend`, `seq` +1 (5-bit wrap).
    - Clear `q_new`, `g_new`, `ovr_pend` and the window counter.
    - Set `drdy`=1 and go to READY.
  - **READY**: `drdy`=1.
    - On `cs_fall`: `drdy`=0 and go to LOCKED.
    - If a new publish condition arises while CS is high: `overrun_cnt`+1 (saturating at 255), `ovr_pend`=1, go to PUBLISH. The unread frame is overwritten.
  - **LOCKED**: frame registers are frozen. On `cs_rise`, go to COLLECT if `q_new|g_new`, else IDLE.
- Simultaneous events:
  - A valid pulse in the PUBLISH cycle goes to the next frame. PUBLISH copies the pre-update shadow, and the new flag stays set.
  - `cs_fall` in the same cycle as a READY republish condition: `cs_fall` wins, go to LOCKED, no overrun.
  - `cs_fall` in the same cycle as PUBLISH: the publish completes, then the next state goes straight to LOCKED.
- Stale counter:
  - Increments each cycle and saturates.
  - Any valid pulse clears the counter and `stale`.
  - `stale`=1 once the count reaches `STALE_CYCLES`.
- Reset values: all frame fields 0, `frame_flags` 0, `drdy` 0, `overrun_cnt` 0, `stale` 0, `seq` 0, state IDLE.
- Reset mid-transaction clears everything. After reset the block waits for fresh valids before publishing.

## Timing
- Publish latency:
  - Completing valid pulse at cycle t: PUBLISH at t+1, frame and `drdy` visible at t+2.
  - Timeout path: frame visible 2 cycles after the counter reaches its terminal value.
- CS handshake: `cs_n` pin falls at t, `cs_fall` at t+2, `drdy` low at t+3.
- A frame may change up to 3 clk after the pin falls. The MCU must keep ≥4 clk (≈84 ns at 48 MHz) between CS low and the first SCK edge.
- Frame outputs are registered and change only in PUBLISH.

## Structure
- Shared package `spi_pkg` holds:
  - `state_t` enum (IDLE, COLLECT, PUBLISH, READY, LOCKED)
  - `HEADER_BYTE`=8'hAA and `PACKET_SIZE`=16
  - flag bit indices `FLAG_QUAT`=0, `FLAG_GYRO`=1, `FLAG_OVR`=2, `FLAG_SEQ_LSB`=3
- Sub-module `sync_2ff`: generic single-bit synchronizer with reset value as a parameter. Used for `cs_n`.

## Test plan
- Reset, then `quat_valid` (w=0x1234) and `gyro_valid` (x=0x0F0F) in the same cycle -> 2 clk later `drdy`=1, `frame_quat_w`=0x1234, `frame_flags`=8'h0B.
- `quat_valid` only, `COLLECT_WINDOW`=16 -> publishes exactly 17 cycles later with `frame_flags[1:0]`=2'b01.
- Two complete frames while CS high and no read -> `overrun_cnt`=1, second frame shows `flags[2]`=1, seq 2.
- CS low, then valids during LOCKED -> frame outputs unchanged until CS high; publish follows ≤3 clk after `cs_rise`.
- `cs_fall` aligned with a READY republish condition -> `overrun_cnt` unchanged, `drdy`=0 3 clk after the pin falls.
- `rst_n` low for 1 cycle mid-LOCKED -> all outputs 0, state IDLE. No valids for `STALE_CYCLES` (set to 100) -> `stale`=1 at cycle 100.
